// File: rtl/reg_wb_queue.sv
// Writeback queue in front of the 8x8 register file: buffers requests and issues one write per clock.
// Define REG_WB_BYPASS_EN to enable the pending-write operand bypass (FWD_HIT/FWD_DATA).
module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     WB_VALID,
    output logic                     WB_READY,
    input  logic [ADDR_W-1:0]        WB_ADDR,
    input  logic [DATA_W-1:0]        WB_DATA,
    input  logic                     HOLD,
    output logic                     RF_WRITE,
    output logic [ADDR_W-1:0]        RF_INADDRESS,
    output logic [DATA_W-1:0]        RF_IN,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     EMPTY,
    input  logic [ADDR_W-1:0]        RD_ADDR1,
    input  logic [ADDR_W-1:0]        RD_ADDR2,
    output logic                     FWD_HIT1,
    output logic [DATA_W-1:0]        FWD_DATA1,
    output logic                     FWD_HIT2,
    output logic [DATA_W-1:0]        FWD_DATA2
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [ADDR_W-1:0] mem_addr_d [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DATA_W-1:0] mem_data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              push, pop;

    assign WB_READY     = !RESET && (count_q < DEPTH_C);
    assign RF_WRITE     = rf_write_q;
    assign RF_INADDRESS = rf_addr_q;
    assign RF_IN        = rf_data_q;
    assign COUNT        = count_q;
    assign EMPTY        = (count_q == '0);

    always_comb begin
        push       = WB_VALID && WB_READY;
        pop        = (count_q != '0) && !HOLD;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rf_write_d = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        if (push) begin
            mem_addr_d[tail_q] = WB_ADDR;
            mem_data_d[tail_q] = WB_DATA;
            tail_d             = tail_q + 1'b1;
        end
        if (pop) begin
            rf_write_d = 1'b1;
            rf_addr_d  = mem_addr_q[head_q];
            rf_data_d  = mem_data_q[head_q];
            head_d     = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_addr_q <= '{default: '0};
            mem_data_q <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

`ifdef REG_WB_BYPASS_EN
    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        FWD_HIT1  = 1'b0;
        FWD_DATA1 = '0;
        FWD_HIT2  = 1'b0;
        FWD_DATA2 = '0;
        if (rf_write_q && (rf_addr_q == RD_ADDR1)) begin
            FWD_HIT1  = 1'b1;
            FWD_DATA1 = rf_data_q;
        end
        if (rf_write_q && (rf_addr_q == RD_ADDR2)) begin
            FWD_HIT2  = 1'b1;
            FWD_DATA2 = rf_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((PTR_W+1)'(i) < count_q) begin
                if (mem_addr_q[idx] == RD_ADDR1) begin
                    FWD_HIT1  = 1'b1;
                    FWD_DATA1 = mem_data_q[idx];
                end
                if (mem_addr_q[idx] == RD_ADDR2) begin
                    FWD_HIT2  = 1'b1;
                    FWD_DATA2 = mem_data_q[idx];
                end
            end
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{RD_ADDR1, RD_ADDR2};
    assign FWD_HIT1  = 1'b0;
    assign FWD_DATA1 = '0;
    assign FWD_HIT2  = 1'b0;
    assign FWD_DATA2 = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Scoreboard bench for reg_wb_queue: stimulus pushes expected writes, a negedge monitor checks RF writes.
module tb_reg_wb_queue;
    logic       CLK, RESET, WB_VALID, WB_READY, HOLD, RF_WRITE, EMPTY;
    logic [2:0] WB_ADDR, RF_INADDRESS, RD_ADDR1, RD_ADDR2;
    logic [7:0] WB_DATA, RF_IN, FWD_DATA1, FWD_DATA2;
    logic [2:0] COUNT;
    logic       FWD_HIT1, FWD_HIT2;

`ifdef REG_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic [10:0] sb[$];
    logic [7:0]  rf_model [8];

    reg_wb_queue #(.DEPTH(4), .DATA_W(8), .ADDR_W(3)) dut (
        .CLK(CLK), .RESET(RESET), .WB_VALID(WB_VALID), .WB_READY(WB_READY),
        .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .HOLD(HOLD), .RF_WRITE(RF_WRITE),
        .RF_INADDRESS(RF_INADDRESS), .RF_IN(RF_IN), .COUNT(COUNT), .EMPTY(EMPTY),
        .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2), .FWD_HIT1(FWD_HIT1),
        .FWD_DATA1(FWD_DATA1), .FWD_HIT2(FWD_HIT2), .FWD_DATA2(FWD_DATA2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) if (RF_WRITE) rf_model[RF_INADDRESS] <= RF_IN;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RF_WRITE === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write at %0t",
                         RF_INADDRESS, RF_IN, $time);
            end else begin
                logic [10:0] exp;
                exp = sb.pop_front();
                check("wb_order", {21'd0, RF_INADDRESS, RF_IN}, {21'd0, exp});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Leaves WB_VALID high so consecutive calls give back-to-back requests.
    task automatic push_req(input logic [2:0] a, input logic [7:0] d);
        bit acc;
        acc      = 1'b0;
        WB_VALID = 1'b1;
        WB_ADDR  = a;
        WB_DATA  = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge CLK);
            acc = WB_READY;
            @(posedge CLK);
            #1;
        end
        if (acc) sb.push_back({a, d});
        else begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got no accept expected accept for addr %0d", a);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            cyc(1);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        cyc(2);
    endtask

    initial begin
        RESET = 1'b1; WB_VALID = 1'b0; WB_ADDR = '0; WB_DATA = '0; HOLD = 1'b0;
        RD_ADDR1 = '0; RD_ADDR2 = '0;
        cyc(3);
        check("ready_in_reset", WB_READY, 0);
        check("rfw_in_reset", RF_WRITE, 0);
        check("count_in_reset", COUNT, 0);
        RESET = 1'b0;
        cyc(1);
        check("idle_ready", WB_READY, 1);
        check("idle_count", COUNT, 0);
        check("idle_empty", EMPTY, 1);
        check("idle_rfw", RF_WRITE, 0);
        check("idle_rfaddr", RF_INADDRESS, 0);

        // single request latency
        push_req(3'd3, 8'h5A);
        WB_VALID = 1'b0;
        check("single_k_rfw", RF_WRITE, 0);
        check("single_k_count", COUNT, 1);
        cyc(1);
        check("single_k1_rfw", RF_WRITE, 1);
        check("single_k1_addr", RF_INADDRESS, 3);
        check("single_k1_data", RF_IN, 8'h5A);
        check("single_k1_empty", EMPTY, 1);
        cyc(1);
        check("single_k2_rfw", RF_WRITE, 0);
        check("single_rf3", rf_model[3], 8'h5A);

        // fill while held, fifth request waits
        HOLD = 1'b1;
        for (int i = 1; i <= 4; i++) push_req(3'(i), 8'(8'h10 + i));
        WB_VALID = 1'b0;
        check("full_count", COUNT, 4);
        check("full_ready", WB_READY, 0);
        check("full_empty", EMPTY, 0);
        check("full_rfw", RF_WRITE, 0);
        WB_VALID = 1'b1; WB_ADDR = 3'd5; WB_DATA = 8'h15;
        cyc(2);
        check("full_held_count", COUNT, 4);
        check("full_held_ready", WB_READY, 0);
        HOLD = 1'b0;
        push_req(3'd5, 8'h15);
        WB_VALID = 1'b0;
        drain();

        // streaming: push and pop every cycle
        for (int i = 0; i < 10; i++) begin
            push_req(3'(i % 8), 8'(8'h30 + i));
            check("stream_count", COUNT, 1);
            check("stream_rfw", RF_WRITE, (i > 0) ? 1 : 0);
        end
        WB_VALID = 1'b0;
        cyc(1);
        check("stream_tail_rfw", RF_WRITE, 1);
        check("stream_tail_count", COUNT, 0);
        cyc(1);
        check("stream_end_rfw", RF_WRITE, 0);

        // reset discards queued entries
        HOLD = 1'b1;
        push_req(3'd6, 8'hA1);
        push_req(3'd7, 8'hA2);
        push_req(3'd0, 8'hA3);
        WB_VALID = 1'b0;
        check("rst_pre_count", COUNT, 3);
        RESET = 1'b1;
        sb.delete();
        cyc(1);
        RESET = 1'b0;
        check("rst_rfw", RF_WRITE, 0);
        check("rst_count", COUNT, 0);
        check("rst_empty", EMPTY, 1);
        HOLD = 1'b0;
        cyc(6);
        check("rst_no_issue", RF_WRITE, 0);

        // bypass lookup
        HOLD = 1'b1;
        push_req(3'd2, 8'h11);
        push_req(3'd2, 8'h22);
        WB_VALID = 1'b0;
        RD_ADDR1 = 3'd2; RD_ADDR2 = 3'd5;
        #1;
        check("byp_hit1", FWD_HIT1, BYP ? 1 : 0);
        check("byp_data1", FWD_DATA1, BYP ? 32'h22 : 0);
        check("byp_hit2", FWD_HIT2, 0);
        check("byp_data2", FWD_DATA2, 0);
        HOLD = 1'b0;
        cyc(1);
        check("byp_iss1_hit1", FWD_HIT1, BYP ? 1 : 0);
        check("byp_iss1_data1", FWD_DATA1, BYP ? 32'h22 : 0);
        cyc(1);
        check("byp_iss2_hit1", FWD_HIT1, BYP ? 1 : 0);
        check("byp_iss2_data1", FWD_DATA1, BYP ? 32'h22 : 0);
        cyc(1);
        check("byp_done_hit1", FWD_HIT1, 0);
        check("byp_done_data1", FWD_DATA1, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Write-side initiator for the 8x8 register file: buffers register writeback requests from the datapath and issues them to the register file write port, one per clock.
- Decouples multi-cycle producers (ALU, load path) from the register file write timing.
- Sits between the writeback mux and the register file's IN/INADDRESS/WRITE inputs.
- Optional read-bypass lets operand fetch see pending writes that have not yet reached the register file.

Parameters:
DEPTH, 4, number of pending-write entries (power of 2, >=2)
DATA_W, 8, register data width
ADDR_W, 3, register address width (8 registers)

Ports:
CLK  input  1  clock, all state updates on posedge
RESET  input  1  synchronous, active-high reset
WB_VALID  input  1  writeback request present
WB_READY  output  1  queue can accept a request this cycle
WB_ADDR  input  ADDR_W  destination register of request
WB_DATA  input  DATA_W  data of request
HOLD  input  1  high = do not issue to register file this cycle
RF_WRITE  output  1  write enable to register file
RF_INADDRESS  output  ADDR_W  write address to register file
RF_IN  output  DATA_W  write data to register file
COUNT  output  clog2(DEPTH)+1  number of queued entries (excludes issue stage)
EMPTY  output  1  COUNT==0
RD_ADDR1  input  ADDR_W  operand 1 register address (bypass lookup)
RD_ADDR2  input  ADDR_W  operand 2 register address (bypass lookup)
FWD_HIT1  output  1  pending write to RD_ADDR1 exists
FWD_DATA1  output  DATA_W  newest pending data for RD_ADDR1
FWD_HIT2  output  1  pending write to RD_ADDR2 exists
FWD_DATA2  output  DATA_W  newest pending data for RD_ADDR2

Behaviour:
- Reset (RESET high at posedge): head/tail pointers, COUNT, RF_WRITE, RF_INADDRESS, RF_IN all 0; all queued and issue-stage entries discarded, no write issued. WB_READY forced 0 while RESET is high.
- Occupancy states: EMPTY (COUNT=0), PARTIAL, FULL (COUNT=DEPTH). Transitions only by push/pop below.
- Push: WB_VALID && WB_READY at posedge writes {WB_ADDR, WB_DATA} at tail; tail wraps modulo DEPTH.
- WB_READY = !RESET && (COUNT < DEPTH). No push when FULL, even if a pop occurs the same cycle.
- Pop/issue: at posedge, if COUNT>0 and !HOLD, head entry is loaded into the issue stage:
  - RF_WRITE<=1, RF_INADDRESS<=addr, RF_IN<=data.
  - Head wraps modulo DEPTH.
  - Otherwise RF_WRITE<=0; RF_INADDRESS/RF_IN hold their last values.
- Latency: request accepted at edge k -> RF_WRITE high for exactly the cycle after edge k+1 -> register file samples at edge k+2. No fall-through on EMPTY.
- Simultaneous push and pop: COUNT unchanged; both pointers advance.
- Throughput: one issue per cycle; back-to-back requests produce consecutive RF_WRITE cycles.
- Ordering: strict FIFO. Duplicate addresses are not coalesced; every accepted request is issued once.
- HOLD mid-stream: queue contents preserved; issue resumes in order at the first edge with HOLD low.
- WB_VALID while FULL: request ignored (not accepted); producer must hold it.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- Defined: FWD_HITn/FWD_DATAn are combinational lookups against all valid queue entries plus the issue stage while RF_WRITE=1.
  - Priority is newest first: tail-1 down to head, then issue stage.
  - On no match, FWD_HITn=0 and FWD_DATAn=0.
- Not defined: FWD_HIT1/2 and FWD_DATA1/2 tied to 0. RD_ADDR1/2 are unused; ports remain present.

Test Plan:
- Reset then idle -> RF_WRITE=0, COUNT=0, EMPTY=1, WB_READY=1 one cycle after RESET drops.
- Single push {addr 3, 0x5A} at edge k -> RF_WRITE=1, RF_INADDRESS=3, RF_IN=0x5A during the cycle after edge k+1 only; register 3 reads 0x5A afterwards.
- HOLD=1 and 5 pushes with DEPTH=4 -> WB_READY=0 after 4 accepts, fifth held. Release HOLD -> writes issue in order 1,2,3,4, then the fifth is accepted and issued.
- Continuous push+pop with 10 requests to addresses 0..7,0,1 -> COUNT stays 1, pointers wrap, 10 consecutive RF_WRITE cycles, data in order.
- RESET asserted with COUNT=3 -> the next cycle has RF_WRITE=0, COUNT=0, and none of the 3 entries is ever issued.
- Bypass (REG_WB_BYPASS_EN) with queue {r2=0x11, r2=0x22} and HOLD=1, RD_ADDR1=2, RD_ADDR2=5 -> FWD_HIT1=1, FWD_DATA1=0x22, FWD_HIT2=0. Without the macro -> both hits 0.
